activation_lut_fetch: RTL

//   Upstream feeder for the activation-function interpolator in each neural-network layer.

---
 rtl/activation_lut_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/activation_lut_fetch.sv
// activation_lut_fetch
//   Feeds the activation-function interpolator. It accepts one signed
//   fixed-point pre-activation x, splits x into a table index and a fractional
//   remainder, and reads the two bracketing samples from a sync-read ROM. It
//   then presents base, next__data, change and remaining under a valid/ready
//   handshake. Only one transaction is in flight at a time.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | in_ready high, waiting for in_valid
//   FETCH_BASE | ROM read at idx
//   FETCH_NEXT | ROM read at idx+1, base sample captured
//   CAPTURE    | next sample, change and remaining captured
//   OUT        | out_valid high, bundle held until out_ready
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   x_in       signed pre-activation (QI.FRAC_W), sampled on accept
//   in_valid   x_in valid
//   in_ready   block idle and able to accept
//   rom_en     ROM read enable
//   rom_addr   ROM read address
//   rom_data   ROM sample, one cycle after rom_en/rom_addr
//   base       sample at idx
//   next__data sample at idx+1
//   change     next__data - base, wrapping
//   remaining  fractional bits of x, zero-extended
//   out_valid  output bundle valid
//   out_ready  consumer accepts bundle
module activation_lut_fetch #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next__data,
    output logic [DATA_W-1:0] change,
    output logic [DATA_W-1:0] remaining,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int IDX_W = DATA_W - FRAC_W;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH_BASE = 3'd1;
    localparam logic [2:0] S_FETCH_NEXT = 3'd2;
    localparam logic [2:0] S_CAPTURE    = 3'd3;
    localparam logic [2:0] S_OUT        = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] x_reg;
    logic [ADDR_W-1:0] idx;

    // Inverting the sign bit turns the signed integer part into offset
    // binary, so the most negative x lands on address 0.
    assign idx = {{(ADDR_W-IDX_W){1'b0}}, ~x_reg[DATA_W-1], x_reg[DATA_W-2:FRAC_W]};

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_OUT);
        rom_en    = 1'b0;
        rom_addr  = '0;
        case (state)
            S_FETCH_BASE: begin
                rom_en   = 1'b1;
                rom_addr = idx;
            end
            S_FETCH_NEXT: begin
                rom_en   = 1'b1;
                // Top bin reads address 2**IDX_W; the table carries that
                // extra entry, so no clamp is needed.
                rom_addr = idx + ADDR_W'(1);
            end
            default: begin
                rom_en   = 1'b0;
                rom_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            x_reg      <= '0;
            base       <= '0;
            next__data <= '0;
            change     <= '0;
            remaining  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg <= x_in;
                        state <= S_FETCH_BASE;
                    end
                end
                S_FETCH_BASE: begin
                    state <= S_FETCH_NEXT;
                end
                S_FETCH_NEXT: begin
                    base  <= rom_data;
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    next__data <= rom_data;
                    change     <= rom_data - base;
                    remaining  <= {{(DATA_W-FRAC_W){1'b0}}, x_reg[FRAC_W-1:0]};
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
